// File: rtl/hangman_rx_pkg.sv
// ---------------------------------------------------------------------------
// hangman_rx_pkg : shared states, ASCII bounds and letter classifiers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hangman_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    PUSH  = 2'b10,
    ERROR = 2'b11
  } rx_state_t;

  localparam logic [7:0] ASCII_UP_LO = 8'h41;
  localparam logic [7:0] ASCII_UP_HI = 8'h5A;
  localparam logic [7:0] ASCII_LO_LO = 8'h61;
  localparam logic [7:0] ASCII_LO_HI = 8'h7A;
  localparam int         CASE_BIT    = 5;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UP_LO) && (b <= ASCII_UP_HI);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LO_LO) && (b <= ASCII_LO_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_letter_fifo.sv
// ---------------------------------------------------------------------------
// rx_letter_fifo : first-word fall-through letter FIFO, zero output when empty
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_letter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_valid,
  output logic       o_full
);

  localparam int           AW     = $clog2(DEPTH);
  localparam logic [AW:0]  C_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == C_FULL);
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & ~o_full;
  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_msg_reg.sv
// ---------------------------------------------------------------------------
// rx_msg_reg : validates received bytes as A-Z letters and queues them
// Optional lowercase folding: RX_LOWER_FOLD_EN. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_msg_reg
  import hangman_rx_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [23:0] ERR_HOLD = 24'd10_000_000,
  parameter int          CNT_W    = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_ready,
  input  logic             rx_err,
  input  logic             letter_ack,
  output logic [7:0]       letter,
  output logic             letter_valid,
  output logic             full,
  output logic             red,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0] C_CASE_MASK = ~(8'h01 << CASE_BIT);

  rx_state_t        r_state;
  logic [7:0]       r_cap_byte;
  logic             r_cap_err;
  logic [23:0]      r_hold;
  logic [CNT_W-1:0] r_err_count;

  logic             w_legal;
  logic [7:0]       w_fold_byte;
  logic             w_push;
  logic             w_drop;
  logic             w_err_evt;
  logic [1:0]       w_inc;
  logic [CNT_W:0]   w_err_sum;

`ifdef RX_LOWER_FOLD_EN
  assign w_legal     = is_upper(r_cap_byte) | is_lower(r_cap_byte);
  assign w_fold_byte = is_lower(r_cap_byte) ? (r_cap_byte & C_CASE_MASK) : r_cap_byte;
`else
  assign w_legal     = is_upper(r_cap_byte);
  assign w_fold_byte = r_cap_byte;
`endif

  assign w_push    = (r_state == PUSH);
  assign w_err_evt = (r_state == ERROR);
  assign w_drop    = rx_ready & (r_state != IDLE);
  assign w_inc     = {1'b0, w_err_evt} + {1'b0, w_drop};
  assign w_err_sum = {1'b0, r_err_count} + (CNT_W + 1)'(w_inc);

  assign red       = (r_hold != '0);
  assign err_count = r_err_count;

  rx_letter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .i_push  (w_push),
    .i_wdata (w_fold_byte),
    .i_pop   (letter_ack),
    .o_rdata (letter),
    .o_valid (letter_valid),
    .o_full  (full)
  );

  // Occupancy is judged in CHECK; a same-cycle pop does not reopen a slot.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= IDLE;
      r_cap_byte <= 8'h00;
      r_cap_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rx_ready) begin
            r_cap_byte <= rx_byte;
            r_cap_err  <= rx_err;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          if (r_cap_err || !w_legal || full) r_state <= ERROR;
          else                               r_state <= PUSH;
        end
        PUSH:    r_state <= IDLE;
        ERROR:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Error events and busy drops share the retriggerable hold and the counter.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_hold      <= '0;
      r_err_count <= '0;
    end else begin
      if (w_err_evt || w_drop) begin
        r_hold <= ERR_HOLD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - 24'd1;
      end
      if (w_err_sum[CNT_W]) r_err_count <= '1;
      else                  r_err_count <= w_err_sum[CNT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_msg_reg.sv
// ---------------------------------------------------------------------------
// tb_rx_msg_reg : directed self-checking bench for rx_msg_reg
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_msg_reg;

  logic       clk = 1'b0;
  logic       nRst;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       rx_err;
  logic       letter_ack;
  logic [7:0] letter;
  logic       letter_valid;
  logic       full;
  logic       red;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rx_msg_reg #(
    .DEPTH    (4),
    .ERR_HOLD (24'd8),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .rx_err       (rx_err),
    .letter_ack   (letter_ack),
    .letter       (letter),
    .letter_valid (letter_valid),
    .full         (full),
    .red          (red),
    .err_count    (err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse rx_ready for one cycle and return in cycle N+3.
  task automatic send(input logic [7:0] b, input logic e);
    rx_byte  = b;
    rx_err   = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_err   = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
  endtask

  task automatic pop();
    letter_ack = 1'b1;
    tick();
    letter_ack = 1'b0;
  endtask

  initial begin
    int n_red;
    nRst       = 1'b0;
    rx_byte    = 8'h00;
    rx_ready   = 1'b0;
    rx_err     = 1'b0;
    letter_ack = 1'b0;
    tick();
    check("rst_letter", letter, 8'h00);
    check("rst_valid", letter_valid, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_red", red, 1'b0);
    check("rst_err", err_count, 8'h00);
    nRst = 1'b1;
    tick();

    // Legal letter latency: nothing visible at N+2, letter at N+3
    rx_byte = 8'h47; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    check("legal_n2_valid", letter_valid, 1'b0);
    tick();
    check("legal_letter", letter, 8'h47);
    check("legal_valid", letter_valid, 1'b1);
    check("legal_red", red, 1'b0);
    check("legal_err", err_count, 8'h00);

    // Framing error: red lit for exactly 8 cycles
    do_reset();
    send(8'h41, 1'b1);
    check("ferr_valid", letter_valid, 1'b0);
    check("ferr_err", err_count, 8'h01);
    n_red = 0;
    for (int i = 0; i < 20; i++) begin
      if (red) n_red++;
      tick();
    end
    check("ferr_red_cycles", n_red, 8);
    check("ferr_red_off", red, 1'b0);

    // Range boundaries '@' and '[' rejected, 'Z' accepted
    do_reset();
    send(8'h40, 1'b0);
    check("bnd_40_err", err_count, 8'h01);
    send(8'h5B, 1'b0);
    check("bnd_5b_err", err_count, 8'h02);
    send(8'h5A, 1'b0);
    check("bnd_5a_letter", letter, 8'h5A);
    check("bnd_5a_err", err_count, 8'h02);

    // Overflow and ordering
    do_reset();
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    check("ovf_not_full3", full, 1'b0);
    send(8'h44, 1'b0);
    check("ovf_full", full, 1'b1);
    send(8'h45, 1'b0);
    check("ovf_err", err_count, 8'h01);
    check("ovf_red", red, 1'b1);
    check("ovf_still_full", full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", letter, 8'h41 + 8'(i));
      check("ovf_order_valid", letter_valid, 1'b1);
      pop();
    end
    check("ovf_empty_valid", letter_valid, 1'b0);
    check("ovf_empty_letter", letter, 8'h00);
    check("ovf_empty_full", full, 1'b0);
    pop();
    send(8'h52, 1'b0);
    check("empty_ack_ignored", letter, 8'h52);
    pop();
    check("empty_ack_count", letter_valid, 1'b0);

    // Busy drop: second pulse while in CHECK is discarded
    do_reset();
    rx_byte = 8'h4B; rx_ready = 1'b1;
    tick();
    rx_byte = 8'h4C;
    tick();
    rx_ready = 1'b0;
    tick();
    check("drop_letter", letter, 8'h4B);
    check("drop_err", err_count, 8'h01);
    check("drop_red", red, 1'b1);
    pop();
    check("drop_only_one", letter_valid, 1'b0);

    // Drop coinciding with ERROR state: +2
    do_reset();
    rx_byte = 8'h31; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    rx_byte = 8'h41; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    check("dual_err", err_count, 8'h02);
    check("dual_valid", letter_valid, 1'b0);

    // Lowercase handling
    do_reset();
    send(8'h6D, 1'b0);
`ifdef RX_LOWER_FOLD_EN
    check("lower_letter", letter, 8'h4D);
    check("lower_err", err_count, 8'h00);
`else
    check("lower_valid", letter_valid, 1'b0);
    check("lower_err", err_count, 8'h01);
`endif

    // Saturation
    do_reset();
    for (int i = 0; i < 300; i++) send(8'h41, 1'b1);
    check("sat_err", err_count, 8'hFF);

    // Asynchronous reset during CHECK, then normal operation
    send(8'h51, 1'b0);
    check("pre_rst_valid", letter_valid, 1'b1);
    rx_byte = 8'h5A; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    #1 nRst = 1'b0;
    #1;
    check("arst_letter", letter, 8'h00);
    check("arst_valid", letter_valid, 1'b0);
    check("arst_full", full, 1'b0);
    check("arst_red", red, 1'b0);
    check("arst_err", err_count, 8'h00);
    tick();
    nRst = 1'b1;
    tick();
    tick();
    check("post_rst_idle", letter_valid, 1'b0);
    send(8'h47, 1'b0);
    check("post_rst_letter", letter, 8'h47);
    check("post_rst_valid", letter_valid, 1'b1);
    check("post_rst_err", err_count, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_msg_reg.md
Name: rx_msg_reg

Overview:
- Receive-side message register: the counterpart of the transmit message register.
- Takes bytes completed by the UART receiver and validates them as guess letters (A-Z).
- Buffers accepted letters in a small FIFO for the game-logic consumer, with a valid/ack handshake.
- Flags rejected bytes on the red LED and in a saturating error counter.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- ERR_HOLD, 24'd10_000_000, cycles red stays lit after an error event.
- CNT_W, 8, width of err_count.

Ports:
- clk  input  1  system clock.
- nRst  input  1  asynchronous, active-low reset.
- rx_byte  input  8  byte from UART receiver; valid only when rx_ready=1.
- rx_ready  input  1  one-cycle pulse: byte complete.
- rx_err  input  1  framing/parity error; qualified by rx_ready.
- letter_ack  input  1  consumer pops the head entry when letter_valid=1.
- letter  output  8  head-of-FIFO letter, uppercase ASCII; 8'h00 when empty.
- letter_valid  output  1  FIFO non-empty.
- full  output  1  FIFO holds DEPTH entries.
- red  output  1  error indicator.
- err_count  output  CNT_W  saturating count of rejected/dropped bytes.

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is asynchronous, active-low on nRst.
  - All outputs are 0 at reset (letter=8'h00, letter_valid=0, full=0, red=0, err_count=0).
  - FIFO is emptied, hold counter cleared, FSM returns to IDLE.
  - Reset mid-operation discards any in-flight byte.
- FSM states: IDLE, CHECK, PUSH, ERROR.
- IDLE:
  - When rx_ready=1, capture rx_byte and rx_err into cap_byte/cap_err, then go to CHECK.
  - Otherwise stay in IDLE.
- CHECK, priority order:
  - cap_err=1 -> ERROR.
  - Byte not a legal letter -> ERROR.
  - full=1 (overflow) -> ERROR.
  - Otherwise -> PUSH.
  - Legal letters: 8'h41..8'h5A. Lowercase is legal only per the optional feature.
- PUSH: write the folded byte into the FIFO, then go to IDLE.
- ERROR: reload the hold counter with ERR_HOLD, increment err_count (saturates at all-ones), then go to IDLE.
- red: 1 while the hold counter is non-zero. The counter decrements by 1 per cycle. A new error reloads it (retrigger).
- Busy drop: rx_ready=1 in CHECK, PUSH or ERROR drops that byte. A drop:
  - increments err_count (saturating);
  - reloads the hold counter;
  - does not change FSM state.
  - If a drop and an ERROR-state increment coincide, err_count increments by 2, still saturating.
- Latency: rx_ready high in cycle N -> letter/letter_valid updated in cycle N+3. A back-to-back legal byte is accepted no earlier than cycle N+3.
- FIFO:
  - First-word fall-through.
  - Pop when letter_valid & letter_ack. letter_ack while empty is ignored.
  - Push and pop in the same cycle: both happen, count unchanged.
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
  - full is evaluated in CHECK. A pop in the CHECK cycle does not rescue an overflow decision.

Optional Feature:
- Macro: RX_LOWER_FOLD_EN.
- Defined: bytes 8'h61..8'h7A are legal and are folded to uppercase (bit 5 cleared) before the push.
- Undefined: lowercase bytes are illegal and go to ERROR.
- Ports and latency are identical either way.

Decomposition:
- Package hangman_rx_pkg holds:
  - typedef enum logic [1:0] rx_state_t: IDLE=2'b00, CHECK=2'b01, PUSH=2'b10, ERROR=2'b11;
  - constants ASCII_UP_LO=8'h41, ASCII_UP_HI=8'h5A, ASCII_LO_LO=8'h61, ASCII_LO_HI=8'h7A, CASE_BIT=5.
- Sub-module rx_letter_fifo (parameter DEPTH) holds storage, pointers, count, full and valid.
- rx_msg_reg instantiates it and holds the FSM, validation, hold counter and err_count.

Test Plan:
- Legal letter: rx_byte=8'h47 with rx_ready pulse in cycle N -> letter=8'h47, letter_valid=1 in cycle N+3; red=0; err_count=0.
- Framing error: rx_byte=8'h41, rx_err=1 -> no push; red=1 for exactly ERR_HOLD cycles (use ERR_HOLD=8 in the bench); err_count=1.
- Overflow and order (DEPTH=4): push 'A','B','C','D' -> full=1. Fifth byte 'E' -> err_count=1, red=1. Pops with letter_ack return 'A','B','C','D' in order, then letter_valid=0 and letter=8'h00.
- Busy drop: rx_ready pulses at cycles N and N+1 with 'K','L' -> only 'K' pushed; err_count=1.
- Lowercase 8'h6D:
  - with RX_LOWER_FOLD_EN -> letter=8'h4D;
  - without it -> no push, err_count=1.
- Saturation and reset:
  - 300 error bytes with CNT_W=8 -> err_count=8'hFF.
  - Assert nRst=0 mid-CHECK -> all outputs 0 immediately; the next legal byte works normally.
